// File: rtl/tlb_ctrl.sv
// CP0-side TLB controller: owns Index/Random/Wired/EntryHi/EntryLo0/EntryLo1 and sequences TLBP/TLBR/TLBWI/TLBWR.
// Optional Wired register is enabled by defining TLB_CTRL_WIRED_EN.
`ifndef TLB_WIDTH
`define TLB_WIDTH 4
`endif

module tlb_ctrl #(
  parameter int unsigned TLB_WIDTH = `TLB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [1:0]           op,
  output logic                 op_ready,
  output logic                 op_done,
  input  logic                 cp0_we,
  input  logic [4:0]           cp0_waddr,
  input  logic [31:0]          cp0_wdata,
  input  logic                 tlb_exc,
  input  logic [31:0]          tlb_exc_vaddr,
  output logic [31:0]          index_o,
  output logic [31:0]          random_o,
  output logic [31:0]          wired_o,
  output logic [31:0]          entrylo0_o,
  output logic [31:0]          entrylo1_o,
  output logic [31:0]          entryhi_o,
  output logic [7:0]           asid_o,
  output logic [85:0]          tlb_config,
  output logic [TLB_WIDTH-1:0] tlb_we_index,
  output logic                 tlb_we,
  output logic                 tlb_p,
  input  logic [31:0]          tlb_p_res_i,
  output logic [TLB_WIDTH-1:0] tlb_read_index,
  input  logic [85:0]          tlb_read_config_i
);

  localparam int unsigned W = TLB_WIDTH;
  localparam logic [W-1:0] RAND_TOP = {W{1'b1}};

  typedef enum logic [2:0] {IDLE, WRITE, PROBE, PCAP, READ, RCAP} state_t;

  state_t         state;
  logic           index_p;
  logic [W-1:0]   index_v;
  logic [W-1:0]   random_q;
  logic [W-1:0]   wired;
  logic [18:0]    hi_vpn2;
  logic [7:0]     hi_asid;
  logic [29:0]    lo0;
  logic [29:0]    lo1;
  logic           wired_wr;
  logic           rand_wrap;
  logic           unused_bits;

  assign unused_bits = ^{tlb_p_res_i[30:W], tlb_exc_vaddr[12:0]};

`ifdef TLB_CTRL_WIRED_EN
  assign wired_wr = cp0_we && (cp0_waddr == 5'd6);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wired <= '0;
    else if (wired_wr) wired <= cp0_wdata[W-1:0];
  end
`else
  assign wired_wr = 1'b0;
  assign wired    = '0;
`endif

  assign rand_wrap = (random_q == wired) || (wired == RAND_TOP);

  assign index_o    = (32'(index_p) << 31) | 32'(index_v);
  assign random_o   = 32'(random_q);
  assign wired_o    = 32'(wired);
  assign entrylo0_o = {2'b00, lo0};
  assign entrylo1_o = {2'b00, lo1};
  assign entryhi_o  = {hi_vpn2, 5'b00000, hi_asid};
  assign asid_o     = hi_asid;

  // Entry image: global bit is the AND of both EntryLo G bits
  assign tlb_config = {hi_vpn2, hi_asid, lo0[0] & lo1[0],
                       lo0[29:6], lo0[5:3], lo0[2], lo0[1],
                       lo1[29:6], lo1[5:3], lo1[2], lo1[1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      op_ready       <= 1'b1;
      op_done        <= 1'b0;
      tlb_we         <= 1'b0;
      tlb_p          <= 1'b0;
      tlb_we_index   <= '0;
      tlb_read_index <= '0;
      index_p        <= 1'b0;
      index_v        <= '0;
      random_q       <= RAND_TOP;
      hi_vpn2        <= '0;
      hi_asid        <= '0;
      lo0            <= '0;
      lo1            <= '0;
    end else begin
      op_done <= 1'b0;
      tlb_we  <= 1'b0;
      tlb_p   <= 1'b0;

      if (wired_wr || rand_wrap) random_q <= RAND_TOP;
      else                       random_q <= random_q - W'(1);

      if (cp0_we) begin
        case (cp0_waddr)
          5'd0:    begin index_p <= cp0_wdata[31]; index_v <= cp0_wdata[W-1:0]; end
          5'd2:    lo0 <= cp0_wdata[29:0];
          5'd3:    lo1 <= cp0_wdata[29:0];
          5'd10:   begin hi_vpn2 <= cp0_wdata[31:13]; hi_asid <= cp0_wdata[7:0]; end
          default: ;
        endcase
      end

      // FSM register loads come after MTC0 so they take priority
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            case (op)
              2'b00: begin state <= PROBE; tlb_p <= 1'b1; end
              2'b01: begin state <= READ; tlb_read_index <= index_v; end
              2'b10: begin state <= WRITE; tlb_we <= 1'b1; op_done <= 1'b1; tlb_we_index <= index_v; end
              2'b11: begin state <= WRITE; tlb_we <= 1'b1; op_done <= 1'b1; tlb_we_index <= random_q; end
              default: ;
            endcase
          end
        end
        WRITE: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        PROBE: begin
          if (tlb_exc) begin
            state    <= IDLE;
            op_ready <= 1'b1;
          end else begin
            state   <= PCAP;
            op_done <= 1'b1;
          end
        end
        PCAP: begin
          index_p  <= tlb_p_res_i[31];
          index_v  <= tlb_p_res_i[W-1:0];
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        READ: begin
          if (tlb_exc) begin
            state    <= IDLE;
            op_ready <= 1'b1;
          end else begin
            state   <= RCAP;
            op_done <= 1'b1;
          end
        end
        RCAP: begin
          hi_vpn2  <= tlb_read_config_i[85:67];
          hi_asid  <= tlb_read_config_i[66:59];
          lo0      <= {tlb_read_config_i[57:29], tlb_read_config_i[58]};
          lo1      <= {tlb_read_config_i[28:0], tlb_read_config_i[58]};
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase

      // Exception commit overrides any other EntryHi.VPN2 source
      if (tlb_exc) hi_vpn2 <= tlb_exc_vaddr[31:13];
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: MTC0 vector table, directed op sequences and a randomized run
// against an arithmetic register/Random model. Honours TLB_CTRL_WIRED_EN like the design.
module tb_tlb_ctrl;

  localparam int W = 4;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        op_ready, op_done;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;
  logic        tlb_exc = 1'b0;
  logic [31:0] tlb_exc_vaddr = '0;
  logic [31:0] index_o, random_o, wired_o, entrylo0_o, entrylo1_o, entryhi_o;
  logic [7:0]  asid_o;
  logic [85:0] tlb_config;
  logic [W-1:0] tlb_we_index, tlb_read_index;
  logic        tlb_we, tlb_p;
  logic [31:0] tlb_p_res_i = '0;
  logic [85:0] tlb_read_config_i = '0;

  tlb_ctrl #(.TLB_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready), .op_done(op_done),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .tlb_exc(tlb_exc), .tlb_exc_vaddr(tlb_exc_vaddr),
    .index_o(index_o), .random_o(random_o), .wired_o(wired_o),
    .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o), .entryhi_o(entryhi_o), .asid_o(asid_o),
    .tlb_config(tlb_config), .tlb_we_index(tlb_we_index), .tlb_we(tlb_we), .tlb_p(tlb_p),
    .tlb_p_res_i(tlb_p_res_i), .tlb_read_index(tlb_read_index), .tlb_read_config_i(tlb_read_config_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int anchor = 0;
  logic [31:0] m_index = 0, m_lo0 = 0, m_lo1 = 0, m_hi = 0;
  int m_wired = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Random counts down from N-1 to Wired then restarts; anchor is the cycle it last showed N-1
  function automatic int exp_random();
    if (m_wired >= N - 1) return N - 1;
    return (N - 1) - ((cyc - anchor) % (N - m_wired));
  endfunction

  function automatic logic [85:0] img(input logic [31:0] hi, input logic [31:0] l0, input logic [31:0] l1);
    logic [85:0] r;
    r = (86'(hi >> 13) << 67) | (86'(hi % 256) << 59) | (86'(l0 % 2 * (l1 % 2)) << 58)
      | (86'((l0 >> 6) % (1 << 24)) << 34) | (86'((l0 >> 3) % 8) << 31)
      | (86'((l0 >> 2) % 2) << 30) | (86'((l0 >> 1) % 2) << 29)
      | (86'((l1 >> 6) % (1 << 24)) << 5) | (86'((l1 >> 3) % 8) << 2)
      | (86'((l1 >> 2) % 2) << 1) | 86'((l1 >> 1) % 2);
    return r;
  endfunction

  function automatic logic [31:0] lo_from(input logic [85:0] cfg, input int base);
    logic [31:0] pfn, c, d, v, g;
    pfn = 32'((cfg >> (base + 5)) % (86'(1) << 24));
    c   = 32'((cfg >> (base + 2)) % 8);
    d   = 32'((cfg >> (base + 1)) % 2);
    v   = 32'((cfg >> base) % 2);
    g   = 32'((cfg >> 58) % 2);
    return (pfn << 6) | (c << 3) | (d << 2) | (v << 1) | g;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".index"}, index_o, m_index);
    chk({tag, ".lo0"}, entrylo0_o, m_lo0);
    chk({tag, ".lo1"}, entrylo1_o, m_lo1);
    chk({tag, ".hi"}, entryhi_o, m_hi);
    chk({tag, ".asid"}, asid_o, m_hi[7:0]);
    chk({tag, ".wired"}, wired_o, 32'(m_wired));
    chk({tag, ".random"}, random_o, 32'(exp_random()));
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    @(negedge clk);
    cp0_we = 1'b0;
    case (a)
      5'd0:  m_index = d & ((32'd1 << 31) | 32'(N - 1));
      5'd2:  m_lo0 = d % (32'd1 << 30);
      5'd3:  m_lo1 = d % (32'd1 << 30);
      5'd10: m_hi = ((d >> 13) << 13) | (d % 256);
`ifdef TLB_CTRL_WIRED_EN
      5'd6:  begin m_wired = int'(d % N); anchor = cyc; end
`endif
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    op_valid = 1'b0; cp0_we = 1'b0; tlb_exc = 1'b0;
    @(negedge clk);
    m_index = 0; m_lo0 = 0; m_lo1 = 0; m_hi = 0; m_wired = 0;
    rst = 1'b1;
    anchor = cyc;
  endtask

  // exc_ph: 0 none, 1 exception in PROBE/READ (abort), 2 exception in PCAP/RCAP
  task automatic run_op(input logic [1:0] o, input logic [31:0] res, input logic [85:0] cfg,
                        input int exc_ph, input logic [31:0] va);
    logic [W-1:0] exp_idx;
    logic [85:0]  exp_img;
    chk("op_ready_idle", op_ready, 1);
    tlb_p_res_i = res;
    tlb_read_config_i = cfg;
    exp_idx = (o == 2'b11) ? W'(exp_random()) : m_index[W-1:0];
    exp_img = img(m_hi, m_lo0, m_lo1);
    op_valid = 1'b1; op = o;
    @(negedge clk);
    chk("op_ready_busy", op_ready, 0);
    if (o[1]) begin
      op = 2'b00;
      chk("we", tlb_we, 1);
      chk("we_done", op_done, 1);
      chk("we_index", tlb_we_index, exp_idx);
      chk("we_config", tlb_config, exp_img);
      chk("we_no_probe", tlb_p, 0);
      @(negedge clk);
      op_valid = 1'b0;
      chk("we_ready_back", op_ready, 1);
      chk("we_pulse", tlb_we, 0);
      chk("we_ignored_valid", tlb_p, 0);
      chk("we_done_pulse", op_done, 0);
    end else begin
      op_valid = 1'b0;
      if (o == 2'b00) chk("probe_strobe", tlb_p, 1);
      else            chk("read_index", tlb_read_index, m_index[W-1:0]);
      chk("early_done", op_done, 0);
      if (exc_ph == 1) begin tlb_exc = 1'b1; tlb_exc_vaddr = va; end
      @(negedge clk);
      tlb_exc = 1'b0;
      if (exc_ph == 1) begin
        chk("abort_no_done", op_done, 0);
        chk("abort_ready", op_ready, 1);
        m_hi = ((va >> 13) << 13) | (m_hi % (32'd1 << 13));
      end else begin
        chk("cap_done", op_done, 1);
        chk("cap_no_strobe", tlb_p, 0);
        if (exc_ph == 2) begin tlb_exc = 1'b1; tlb_exc_vaddr = va; end
      end
      @(negedge clk);
      tlb_exc = 1'b0;
      if (exc_ph != 1) begin
        chk("done_pulse", op_done, 0);
        if (o == 2'b00) m_index = res & ((32'd1 << 31) | 32'(N - 1));
        else begin
          m_hi  = (32'(cfg >> 67) << 13) | 32'((cfg >> 59) % 256);
          m_lo0 = lo_from(cfg, 29);
          m_lo1 = lo_from(cfg, 0);
        end
        if (exc_ph == 2) m_hi = ((va >> 13) << 13) | (m_hi % (32'd1 << 13));
      end
      chk("ready_after", op_ready, 1);
      check_regs("op");
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          sel;   // 0 index, 1 random, 2 lo0, 3 lo1, 4 wired, 5 hi
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] sel_out(input int s);
    case (s)
      0: return index_o;
      1: return random_o;
      2: return entrylo0_o;
      3: return entrylo1_o;
      4: return wired_o;
      default: return entryhi_o;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    logic [85:0] wimg;
    logic [95:0] rnd96;
    logic [4:0]  addrs[7];
    vecs[0]  = '{5'd10, 32'h1234_50AB, 5, 32'h1234_40AB};
    vecs[1]  = '{5'd2,  32'hFFFF_FFFF, 2, 32'h3FFF_FFFF};
    vecs[2]  = '{5'd3,  32'hC000_0000, 3, 32'h0000_0000};
    vecs[3]  = '{5'd0,  32'hFFFF_FFFF, 0, 32'h8000_000F};
    vecs[4]  = '{5'd1,  32'h0000_0005, 1, 32'h0};
`ifdef TLB_CTRL_WIRED_EN
    vecs[5]  = '{5'd6,  32'hFFFF_FFF7, 4, 32'h7};
`else
    vecs[5]  = '{5'd6,  32'hFFFF_FFF7, 4, 32'h0};
`endif
    vecs[6]  = '{5'd6,  32'h0000_0000, 4, 32'h0};
    vecs[7]  = '{5'd0,  32'h0000_0005, 0, 32'h0000_0005};
    vecs[8]  = '{5'd2,  32'h0000_1007, 2, 32'h0000_1007};
    vecs[9]  = '{5'd3,  32'h0000_2017, 3, 32'h0000_2017};
    vecs[10] = '{5'd4,  32'hFFFF_FFFF, 0, 32'h0000_0005};
    addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd10, 5'd4};

    // reset state and first Random steps
    @(negedge clk); @(negedge clk);
    chk("rst_random", random_o, N - 1);
    chk("rst_ready", op_ready, 1);
    chk("rst_done", op_done, 0);
    chk("rst_we", tlb_we, 0);
    chk("rst_p", tlb_p, 0);
    chk("rst_config", tlb_config, 0);
    rst = 1'b1;
    anchor = cyc;
    check_regs("rst");
    @(negedge clk);
    chk("rand_n2", random_o, N - 2);
    @(negedge clk);
    chk("rand_n3", random_o, N - 3);

    foreach (vecs[i]) begin
      mtc0(vecs[i].addr, vecs[i].data);
      if (vecs[i].sel == 1) chk("vec_random", sel_out(1), 32'(exp_random()));
      else                  chk($sformatf("vec%0d", i), sel_out(vecs[i].sel), vecs[i].exp);
    end
    check_regs("table");

    // TLBWI of the known entry
    run_op(2'b10, 0, 0, 0, 0);
    wimg = img(32'h1234_40AB, 32'h1007, 32'h2017);
    chk("wi_img", img(m_hi, m_lo0, m_lo1), wimg);
    op = 2'b10; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("wi_index5", tlb_we_index, 5);
    chk("wi_vpn2", tlb_config[85:67], 19'h091A2);
    chk("wi_asid", tlb_config[66:59], 8'hAB);
    chk("wi_g", tlb_config[58], 1);
    chk("wi_pfn0", tlb_config[57:34], 24'h40);
    chk("wi_pfn1", tlb_config[28:5], 24'h80);
    @(negedge clk);

    // TLBP miss then hit
    run_op(2'b00, 32'h8000_0000, 0, 0, 0);
    chk("probe_miss", index_o, 32'h8000_0000);
    run_op(2'b00, 32'h0000_0003, 0, 0, 0);
    chk("probe_hit", index_o, 32'h3);

    // TLBR restores cleared registers from the written image
    mtc0(5'd2, 0); mtc0(5'd3, 0); mtc0(5'd10, 0);
    run_op(2'b01, 0, wimg, 0, 0);
    chk("tlbr_lo0", entrylo0_o, 32'h0000_1007);
    chk("tlbr_lo1", entrylo1_o, 32'h0000_2017);
    chk("tlbr_hi", entryhi_o, 32'h1234_40AB);

`ifdef TLB_CTRL_WIRED_EN
    mtc0(5'd6, N - 2);
    chk("wired_r0", random_o, N - 1);
    @(negedge clk);
    chk("wired_r1", random_o, N - 2);
    @(negedge clk);
    chk("wired_r2", random_o, N - 1);
`endif
    run_op(2'b11, 0, 0, 0, 0);

    // exception aborts a probe
    run_op(2'b00, 32'h5, 0, 1, 32'hDEAD_B000);
    chk("exc_index", index_o, 32'h3);
    chk("exc_vpn2", entryhi_o[31:13], 19'h6F56D);

    // reset in the middle of a probe
    op = 2'b00; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("mid_p", tlb_p, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_p_off", tlb_p, 0);
    chk("mid_ready", op_ready, 1);
    chk("mid_hi", entryhi_o, 0);
    chk("mid_random", random_o, N - 1);
    do_reset();
    @(negedge clk);
    chk("mid_no_done", op_done, 0);
    check_regs("post_rst");

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        mtc0(addrs[$urandom_range(0, 6)], $urandom);
        check_regs("rnd_mtc0");
      end else begin
        logic [1:0] o;
        o = 2'($urandom_range(0, 3));
        rnd96 = {$urandom, $urandom, $urandom};
        run_op(o, $urandom, rnd96[85:0], o[1] ? 0 : int'($urandom_range(0, 2)), $urandom);
        if (o[1]) check_regs("rnd_write");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
